// File: rtl/pow8_result_fifo_if.sv
// Handshake bundle between the power-of-8 stage, the result FIFO and its consumer.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface pow8_result_fifo_if #(
  parameter int DATA_W = 64,
  parameter int AW     = 3
);
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic              o_full;
  logic              o_empty;
  logic [AW:0]       o_count;
  logic              o_overflow;
  logic              i_clear_ovf;

  modport master (
    output i_valid, i_data, i_ready, i_clear_ovf,
    input  o_valid, o_data, o_full, o_empty, o_count, o_overflow
  );

  modport slave (
    input  i_valid, i_data, i_ready, i_clear_ovf,
    output o_valid, o_data, o_full, o_empty, o_count, o_overflow
  );
endinterface

// File: rtl/pow8_result_fifo.sv
// First-word-fall-through result buffer behind the power-of-8 stage; absorbs
// consumer stalls and records any result dropped while full in a sticky flag.
module pow8_result_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pow8_result_fifo_if.slave     bus
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              ovf;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
  assign pop   = ~empty & bus.i_ready;
  assign push  = bus.i_valid & (~full | pop);
  assign drop  = bus.i_valid & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.i_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear request leaves the flag set.
      if (drop)                 ovf <= 1'b1;
      else if (bus.i_clear_ovf) ovf <= 1'b0;
    end
  end

  assign bus.o_valid    = ~empty;
  assign bus.o_data     = mem[rd_ptr];
  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_count    = count;
  assign bus.o_overflow = ovf;

endmodule

// File: tb/tb_pow8_result_fifo.sv
// Scoreboard bench for pow8_result_fifo: a driver predicts accepted results into a
// queue, and a negedge monitor pops and compares whatever the FIFO presents.
module tb_pow8_result_fifo;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pow8_result_fifo_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  pow8_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DATA_W-1:0] exp_q[$];
  logic              ovf_exp = 1'b0;
  logic              mon_en  = 1'b0;
  int                max_cnt = 0;
  int                total   = 0;
  int                passes  = 0;

  function automatic logic [63:0] pow8(input int unsigned b);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < 8; k++) r = r * 64'(b);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
  endtask

  // Monitor: compares presented head against the scoreboard and retires it on a pop.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      chk("o_valid", 64'(bus.o_valid), 64'(exp_q.size() > 0));
      chk("o_count", 64'(bus.o_count), 64'(exp_q.size()));
      chk("o_full", 64'(bus.o_full), 64'(exp_q.size() == DEPTH));
      chk("o_empty", 64'(bus.o_empty), 64'(exp_q.size() == 0));
      chk("o_overflow", 64'(bus.o_overflow), 64'(ovf_exp));
      if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
      if (bus.o_valid && exp_q.size() > 0) chk("o_data", bus.o_data, exp_q[0]);
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) chk("pop_from_empty_model", 64'd1, 64'd0);
        else void'(exp_q.pop_front());
      end
    end
  end

  // Driver: applies one cycle of stimulus and commits the predicted effect after the edge.
  task automatic step(input logic v, input logic [63:0] d, input logic r, input logic c);
    int   sz;
    logic pop_e, push_e, drop_e;
    sz = exp_q.size();
    bus.i_valid     = v;
    bus.i_data      = d;
    bus.i_ready     = r;
    bus.i_clear_ovf = c;
    pop_e  = (sz > 0) && r;
    push_e = v && ((sz < DEPTH) || pop_e);
    drop_e = v && !push_e;
    @(posedge clk);
    #1;
    if (push_e) exp_q.push_back(d);
    if (drop_e) ovf_exp = 1'b1;
    else if (c) ovf_exp = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_ready = 1'b0;
    bus.i_clear_ovf = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 64'd0, 1'b1, 1'b0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #10;
    chk("rst_o_empty", 64'(bus.o_empty), 64'd1);
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_count", 64'(bus.o_count), 64'd0);
    chk("rst_o_overflow", 64'(bus.o_overflow), 64'd0);
    chk("rst_o_data", bus.o_data, 64'd0);
    chk("rst_o_full", 64'(bus.o_full), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(1'b0, 64'd0, 1'b0, 1'b0);

    // Single result held under backpressure, then accepted.
    step(1'b1, 64'd256, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0);

    // Fill and overflow: the ninth value is dropped and the flag stays set through the drain.
    for (int i = 0; i <= 8; i++) step(1'b1, pow8(i), 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0);
    drain(DEPTH);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) step(1'b1, pow8(i), 1'b0, 1'b0);
    step(1'b1, pow8(8), 1'b1, 1'b0);
    drain(DEPTH);

    // Back-to-back streaming with the consumer always ready.
    max_cnt = 0;
    for (int i = 0; i < 100; i++) step(1'b1, pow8(i), 1'b1, 1'b0);
    drain(2);
    chk("stream_max_count", 64'(max_cnt), 64'(max_cnt <= 1 ? max_cnt : 1));

    // Randomized traffic mixing stalls, bursts, drops and clears.
    for (int n = 0; n < 400; n++) begin
      logic [63:0] d;
      if ($urandom_range(0, 1) == 0) d = pow8($urandom_range(0, 99));
      else d = {$urandom, $urandom};
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end
    drain(DEPTH + 1);
    step(1'b0, 64'd0, 1'b0, 1'b1);

    // Reset mid-stream with five entries stored.
    for (int i = 1; i <= 5; i++) step(1'b1, pow8(i + 10), 1'b0, 1'b0);
    idle_inputs();
    #2;
    chk("pre_reset_count", 64'(bus.o_count), 64'd5);
    reset_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    chk("async_rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("async_rst_o_count", 64'(bus.o_count), 64'd0);
    exp_q.delete();
    ovf_exp = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(1'b1, 64'd256, 1'b0, 1'b0);
    chk("post_reset_head", bus.o_data, 64'd256);
    drain(2);

    mon_en = 1'b0;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
